// File: rtl/dm_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its trace FIFO.
package dm_responder_pkg;

    // Responder FSM: clear sweep after reset, then normal operation forever.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // All four byte lanes enabled (full-word store).
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    // Store-commit trace entry layout.
    localparam int TR_PC_W    = 32;
    localparam int TR_ADDR_W  = 32;
    localparam int TR_DATA_W  = 32;
    localparam int TR_BE_W    = 4;
    localparam int TR_ENTRY_W = TR_PC_W + TR_ADDR_W + TR_DATA_W + TR_BE_W;

    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_ADDR_W-1:0] addr;
        logic [TR_DATA_W-1:0] data;
        logic [TR_BE_W-1:0]   be;
    } tr_entry_t;

    // Replace the enabled byte lanes of old_word with the lanes of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_word[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_responder_trace_fifo.sv
// Synchronous FIFO for the store-commit trace stream.
// Handshake: pop_valid means the head entry on pop_data is meaningful; an
// entry leaves only on a rising edge where pop_valid && pop_ready, and
// pop_data holds steady while pop_valid && !pop_ready. A push is taken when
// there is room or a pop happens in the same cycle; otherwise it is dropped
// and the drop output pulses for that cycle.
module dm_responder_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [W-1:0]               push_data,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [W-1:0]               pop_data,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full;
    logic          pop_fire;
    logic          push_fire;

    // Next pointers/occupancy from the push and pop decisions of this cycle.
    always_comb begin
        full      = (count_q == FULL_CNT);
        pop_valid = (count_q != '0);
        pop_fire  = pop_valid && pop_ready;
        push_fire = push_valid && (!full || pop_fire);
        drop      = push_valid && full && !pop_fire;
        wr_ptr_d  = push_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_fire  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push_fire && !pop_fire) count_d = count_q + (PW + 1)'(1);
        if (!push_fire && pop_fire) count_d = count_q - (PW + 1)'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_fire) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: word storage with post-reset clear sweep, byte-lane
// writes, zero-latency reads and a store-commit trace stream.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] BASE     = 32'h0000_0000,
    parameter int          TR_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        init_busy,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [31:0] tr_pc,
    output logic [31:0] tr_addr,
    output logic [31:0] tr_data,
    output logic [3:0]  tr_byteen,
    output logic        tr_overflow,
    output logic [7:0]  tr_drop_cnt,
    output logic        err_oor,
    output logic        err_init,
    output state_e      dbg_state
);

    localparam int          WORDS       = 2 ** ADDR_W;
    localparam logic [32:0] RANGE_BYTES = 33'd4 << ADDR_W;

    logic [31:0]       mem_q [WORDS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              init_busy_q, init_busy_d;
    logic              err_oor_q, err_oor_d;
    logic              err_init_q, err_init_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic [31:0]       off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic              is_run;
    logic              wr_req;
    logic              do_write;
    tr_entry_t         push_entry;
    tr_entry_t         head_entry;
    logic [TR_ENTRY_W-1:0] head_bits;
    logic              fifo_drop;
    logic [$clog2(TR_DEPTH):0] tr_occ;
    logic              unused_bits;

    // Address decode, byte merge and read path.
    always_comb begin
        off      = m_data_addr - BASE;
        in_range = ({1'b0, m_data_addr} >= {1'b0, BASE}) && ({1'b0, off} < RANGE_BYTES);
        idx      = off[ADDR_W+1:2];
        old_word = mem_q[idx];
        merged   = merge_lanes(old_word, m_data_wdata, m_data_byteen);
        is_run   = (state_q == ST_RUN);
        wr_req   = (m_data_byteen != 4'b0000);
        do_write = is_run && wr_req && in_range;
        m_data_rdata = (is_run && in_range) ? old_word : 32'h0;
        push_entry.pc   = m_inst_addr;
        push_entry.addr = BASE + (32'(idx) << 2);
        push_entry.data = merged;
        push_entry.be   = m_data_byteen;
    end

    // Clear-sweep FSM next state: one word per cycle, then RUN forever.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_CLEAR: begin
                sweep_d = sweep_q + ADDR_W'(1);
                if (&sweep_q) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end
            end
            ST_RUN: ;
            default: state_d = ST_CLEAR;
        endcase
    end

    // FSM registers with registered init_busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            sweep_q     <= '0;
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Sticky error/overflow flags and saturating drop counter next values.
    always_comb begin
        err_oor_d  = err_oor_q  | (is_run && wr_req && !in_range);
        err_init_d = err_init_q | (!is_run && wr_req);
        overflow_d = overflow_q | fifo_drop;
        drop_cnt_d = drop_cnt_q;
        if (fifo_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_oor_q  <= 1'b0;
            err_init_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            err_oor_q  <= err_oor_d;
            err_init_q <= err_init_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage: the sweep zeroes one word per cycle; afterwards accepted stores land here.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[sweep_q] <= 32'h0;
        end else if (do_write) begin
            mem_q[idx] <= merged;
        end
    end

    dm_responder_trace_fifo #(
        .DEPTH (TR_DEPTH),
        .W     (TR_ENTRY_W)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (do_write),
        .push_data  (push_entry),
        .pop_valid  (tr_valid),
        .pop_ready  (tr_ready),
        .pop_data   (head_bits),
        .drop       (fifo_drop),
        .occupancy  (tr_occ)
    );

    assign head_entry  = tr_entry_t'(head_bits);
    assign tr_pc       = head_entry.pc;
    assign tr_addr     = head_entry.addr;
    assign tr_data     = head_entry.data;
    assign tr_byteen   = head_entry.be;
    assign init_busy   = init_busy_q;
    assign tr_overflow = overflow_q;
    assign tr_drop_cnt = drop_cnt_q;
    assign err_oor     = err_oor_q;
    assign err_init    = err_init_q;
    assign dbg_state   = state_q;

    // Address bits below the word and above the decoded range do not select storage.
    assign unused_bits = ^{off[1:0], off[31:ADDR_W+2], tr_occ};

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with ADDR_W=4, TR_DEPTH=8.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        init_busy;
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_pc;
  logic [31:0] tr_addr;
  logic [31:0] tr_data;
  logic [3:0]  tr_byteen;
  logic        tr_overflow;
  logic [7:0]  tr_drop_cnt;
  logic        err_oor;
  logic        err_init;
  state_e      dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_data_q[$];
  int model_occ;
  int model_drops;

  dm_responder #(
    .ADDR_W   (4),
    .BASE     (32'h0000_0000),
    .TR_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .init_busy     (init_busy),
    .tr_valid      (tr_valid),
    .tr_ready      (tr_ready),
    .tr_pc         (tr_pc),
    .tr_addr       (tr_addr),
    .tr_data       (tr_data),
    .tr_byteen     (tr_byteen),
    .tr_overflow   (tr_overflow),
    .tr_drop_cnt   (tr_drop_cnt),
    .err_oor       (err_oor),
    .err_init      (err_init),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a store for one rising edge, then remove the byte enables.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
    tick();
    m_data_byteen = 4'h0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a;
    #1;
    check(tag, m_data_rdata, exp);
  endtask

  // Count rising edges until init_busy drops; returns the count (bounded).
  task automatic count_sweep(output int n, input bit poke_write);
    n = 0;
    while (init_busy && n < 100) begin
      tick();
      n++;
      if (poke_write && n == 3) begin
        m_data_addr   = 32'h20;
        m_data_wdata  = 32'hFFFF_FFFF;
        m_data_byteen = BYTEEN_WORD;
        m_inst_addr   = 32'h1000;
      end
      if (n == 4) m_data_byteen = 4'h0;
    end
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = '0;
    m_inst_addr   = '0;
    tr_ready      = 1'b0;
    model_occ     = 0;
    model_drops   = 0;

    // reset state
    repeat (3) tick();
    check("rst_init_busy", init_busy, 1);
    check("rst_tr_valid", tr_valid, 0);
    check("rst_tr_pc", tr_pc, 0);
    check("rst_overflow", tr_overflow, 0);
    check("rst_drop_cnt", tr_drop_cnt, 0);
    check("rst_err_oor", err_oor, 0);
    check("rst_err_init", err_init, 0);

    // sweep length, with a store attempted mid-sweep
    @(negedge clk);
    reset = 1'b1;
    count_sweep(n, 1'b1);
    check("sweep_len", n, 16);
    check("run_state", dbg_state, ST_RUN);
    check("err_init_set", err_init, 1);
    check("err_oor_clear", err_oor, 0);
    check("tr_empty_after_sweep", tr_valid, 0);
    for (int i = 0; i < 16; i++) check_read($sformatf("clear_rd_%0d", i), 32'(4 * i), 32'h0);

    // full-word store
    m_data_addr   = 32'h10;
    m_data_wdata  = 32'h1234_5678;
    m_data_byteen = BYTEEN_WORD;
    m_inst_addr   = 32'h3004;
    #1;
    check("same_cycle_old", m_data_rdata, 32'h0);
    tick();
    m_data_byteen = 4'h0;
    #1;
    check("wr_full_rd", m_data_rdata, 32'h1234_5678);
    check("tr1_valid", tr_valid, 1);
    check("tr1_pc", tr_pc, 32'h3004);
    check("tr1_addr", tr_addr, 32'h10);
    check("tr1_data", tr_data, 32'h1234_5678);
    check("tr1_be", tr_byteen, 4'hF);

    // single-lane store into the same word
    drive_write(32'h12, 32'h00AB_0000, 4'b0100, 32'h3008);
    check_read("wr_lane_rd", 32'h10, 32'h12AB_5678);
    check("tr_head_stable", tr_pc, 32'h3004);
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
    check("tr2_pc", tr_pc, 32'h3008);
    check("tr2_addr", tr_addr, 32'h10);
    check("tr2_data", tr_data, 32'h12AB_5678);
    check("tr2_be", tr_byteen, 4'b0100);
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
    check("tr_empty_after_pops", tr_valid, 0);

    // nine stores into an eight-entry trace FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      drive_write(32'(4 * i), 32'hA000_0000 | 32'(i), BYTEEN_WORD, 32'h4000 + 32'(4 * i));
      if (model_occ < 8) begin
        exp_pc_q.push_back(32'h4000 + 32'(4 * i));
        exp_data_q.push_back(32'hA000_0000 | 32'(i));
        model_occ++;
      end else begin
        model_drops++;
      end
    end
    check("ovf_flag", tr_overflow, 1);
    check("ovf_drop_cnt", tr_drop_cnt, 32'(model_drops));
    tr_ready = 1'b1;
    n = 0;
    while (exp_pc_q.size() > 0 && n < 20) begin
      check($sformatf("drain_valid_%0d", n), tr_valid, 1);
      check($sformatf("drain_pc_%0d", n), tr_pc, exp_pc_q.pop_front());
      check($sformatf("drain_data_%0d", n), tr_data, exp_data_q.pop_front());
      tick();
      n++;
    end
    tr_ready = 1'b0;
    check("drain_count", n, 8);
    check("drain_empty", tr_valid, 0);

    // out-of-range store
    drive_write(32'h40, 32'hDEAD_BEEF, BYTEEN_WORD, 32'h5000);
    check("oor_flag", err_oor, 1);
    check("oor_no_trace", tr_valid, 0);
    check_read("oor_rd", 32'h40, 32'h0);
    check_read("oor_no_alias", 32'h0, 32'hA000_0000);
    check_read("dropped_still_stored", 32'h20, 32'hA000_0008);

    // reset in the middle of a sweep
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (7) tick();
    check("midsweep_busy", init_busy, 1);
    reset = 1'b0;
    #1;
    check("rst2_busy", init_busy, 1);
    check("rst2_overflow", tr_overflow, 0);
    check("rst2_drop_cnt", tr_drop_cnt, 0);
    check("rst2_err_oor", err_oor, 0);
    check("rst2_err_init", err_init, 0);
    check("rst2_tr_valid", tr_valid, 0);
    check("rst2_tr_data", tr_data, 0);
    @(negedge clk);
    reset = 1'b1;
    count_sweep(n, 1'b0);
    check("sweep2_len", n, 16);
    check("sweep2_flags", {err_oor, err_init, tr_overflow, tr_valid}, 0);
    check_read("sweep2_rd0", 32'h0, 32'h0);
    check_read("sweep2_rd20", 32'h20, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
